// File: rtl/rv_mem_wb_pkg.sv
// rv_mem_wb_pkg: opcode/funct3 constants, bubble instruction and FSM encoding for the MEM stage.
package rv_mem_wb_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RSP = 2'd2} state_t;
endpackage

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: byte-lane strobes, store replication, load extraction and access legality.
module rv_lsu_align
    import rv_mem_wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  lane,
    input  logic [31:0] rs2,
    input  logic [31:0] rsp_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        fault
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        illegal;
    logic        misaligned;
    always_comb begin
        byte_sel   = rsp_data[{lane, 3'b000} +: 8];
        half_sel   = lane[1] ? rsp_data[31:16] : rsp_data[15:0];
        illegal    = is_load  ? !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) :
                     is_store && !(funct3 inside {F3_B, F3_H, F3_W});
        misaligned = (funct3[1:0] == 2'b01 && lane[0]) || (funct3[1:0] == 2'b10 && lane != 2'b00);
        fault      = (is_load || is_store) && (illegal || misaligned);
        wstrb      = !is_store              ? 4'b0000 :
                     funct3[1:0] == 2'b00   ? 4'b0001 << lane :
                     funct3[1:0] == 2'b01   ? 4'b0011 << lane : 4'b1111;
        wdata      = funct3[1:0] == 2'b00 ? {4{rs2[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{rs2[15:0]}} : rs2;
        // funct3[2] selects the unsigned variants
        load_data  = funct3[1:0] == 2'b00 ? {{24{byte_sel[7] & ~funct3[2]}}, byte_sel} :
                     funct3[1:0] == 2'b01 ? {{16{half_sel[15] & ~funct3[2]}}, half_sel} : rsp_data;
    end
endmodule

// File: rtl/rv_mem_wb.sv
// rv_mem_wb: RV32 MEM stage with valid/ready data-memory port, upstream stall and MEM/WB registers.
module rv_mem_wb
    import rv_mem_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_ir,
    input  logic [31:0] ex_mem_alu,
    input  logic [31:0] ex_mem_rs2,
    output logic        mem_stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_data,
    output logic        mem_wb_valid,
    output logic [31:0] mem_wb_ir,
    output logic [31:0] mem_wb_out,
    output logic        mem_fault
);
    state_t      state, state_nx;
    logic [6:0]  opcode;
    logic        is_load, is_store, align_fault, fault_now, retire;
    logic [31:0] load_data, retire_ir;

    assign opcode        = ex_mem_ir[6:0];
    assign is_load       = ex_mem_valid && opcode == OP_LOAD;
    assign is_store      = ex_mem_valid && opcode == OP_STORE;
    assign fault_now     = state == S_IDLE && align_fault;
    assign dmem_req_we   = is_store;
    assign dmem_req_addr = {ex_mem_alu[31:2], 2'b00};
    // branches and stores never write rd, so their rd field must not reach writeback
    assign retire_ir     = (opcode == OP_STORE || opcode == OP_BRANCH) ?
                           {ex_mem_ir[31:12], 5'b00000, ex_mem_ir[6:0]} : ex_mem_ir;

    rv_lsu_align u_align (
        .funct3    (ex_mem_ir[14:12]),
        .is_load   (is_load),
        .is_store  (is_store),
        .lane      (ex_mem_alu[1:0]),
        .rs2       (ex_mem_rs2),
        .rsp_data  (dmem_rsp_data),
        .wstrb     (dmem_req_wstrb),
        .wdata     (dmem_req_wdata),
        .load_data (load_data),
        .fault     (align_fault)
    );

    always_comb begin
        state_nx       = state;
        dmem_req_valid = 1'b0;
        mem_stall      = 1'b0;
        retire         = 1'b0;
        case (state)
            S_IDLE: begin
                if ((is_load || is_store) && !align_fault) begin
                    dmem_req_valid = 1'b1;
                    if (!dmem_req_ready) begin
                        state_nx  = S_REQ;
                        mem_stall = 1'b1;
                    end else if (is_load) begin
                        state_nx  = S_RSP;
                        mem_stall = 1'b1;
                    end else begin
                        retire = 1'b1;
                    end
                end else begin
                    retire = ex_mem_valid && !align_fault;
                end
            end
            S_REQ: begin
                dmem_req_valid = 1'b1;
                if (!dmem_req_ready) begin
                    mem_stall = 1'b1;
                end else if (is_load) begin
                    state_nx  = S_RSP;
                    mem_stall = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                    retire   = 1'b1;
                end
            end
            S_RSP: begin
                if (dmem_rsp_valid) begin
                    state_nx = S_IDLE;
                    retire   = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            mem_wb_valid <= 1'b0;
            mem_wb_ir    <= NOP_INSTR;
            mem_wb_out   <= 32'h0;
            mem_fault    <= 1'b0;
        end else begin
            state        <= state_nx;
            mem_wb_valid <= retire;
            mem_wb_ir    <= retire ? retire_ir : NOP_INSTR;
            mem_wb_out   <= retire ? (is_load ? load_data : ex_mem_alu) : 32'h0;
            mem_fault    <= fault_now;
        end
    end
endmodule

// File: tb/tb_rv_mem_wb.sv
// tb_rv_mem_wb: scenario tasks with inline checks; retirements are checked against a scoreboard queue.
module tb_rv_mem_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_mem_valid = 1'b0;
    logic [31:0] ex_mem_ir = 32'h13, ex_mem_alu = 32'h0, ex_mem_rs2 = 32'h0;
    logic        mem_stall, dmem_req_valid, dmem_req_we;
    logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_req_addr, dmem_req_wdata, mem_wb_ir, mem_wb_out;
    logic [31:0] dmem_rsp_data = 32'h0;
    logic [3:0]  dmem_req_wstrb;
    logic        mem_wb_valid, mem_fault;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] out;
        bit          chk_out;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    rv_mem_wb dut (
        .clk(clk), .rst(rst),
        .ex_mem_valid(ex_mem_valid), .ex_mem_ir(ex_mem_ir), .ex_mem_alu(ex_mem_alu), .ex_mem_rs2(ex_mem_rs2),
        .mem_stall(mem_stall),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
        .mem_wb_valid(mem_wb_valid), .mem_wb_ir(mem_wb_ir), .mem_wb_out(mem_wb_out), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && mem_wb_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL retire_unexpected ir=%h out=%h", mem_wb_ir, mem_wb_out);
            end else begin
                e = sbq.pop_front();
                if (mem_wb_ir !== e.ir || (e.chk_out && mem_wb_out !== e.out)) begin
                    failures++;
                    $display("FAIL retire got ir=%h out=%h exp ir=%h out=%h", mem_wb_ir, mem_wb_out, e.ir, e.out);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] rs2);
        ex_mem_valid = v;
        ex_mem_ir    = ir;
        ex_mem_alu   = alu;
        ex_mem_rs2   = rs2;
    endtask

    task automatic push(input logic [31:0] ir, input logic [31:0] out, input bit chk);
        sbq.push_back('{ir: ir, out: out, chk_out: chk});
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #2;
        checks++;
        if ({mem_wb_valid, mem_wb_ir, mem_wb_out, mem_fault} !== {1'b0, 32'h13, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset got v=%b ir=%h out=%h f=%b exp v=0 ir=00000013 out=0 f=0",
                     mem_wb_valid, mem_wb_ir, mem_wb_out, mem_fault);
        end
        step;
        step;
        rst = 1'b1;
    endtask

    task automatic test_alu(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] exp_ir);
        drive(1'b1, ir, alu, 32'h0);
        push(exp_ir, alu, 1'b1);
        @(negedge clk);
        checks++;
        if ({mem_stall, dmem_req_valid} !== 2'b00) begin
            failures++;
            $display("FAIL alu_noreq ir=%h got stall=%b req=%b exp 0 0", ir, mem_stall, dmem_req_valid);
        end
        step;
        drive(1'b0, 32'h13, 32'h0, 32'h0);
    endtask

    task automatic test_idle_noreq;
        drive(1'b0, 32'h0000A283, 32'h100, 32'h0);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_stall, dmem_req_valid} !== 2'b00) begin
            failures++;
            $display("FAIL invalid_load got stall=%b req=%b exp 0 0", mem_stall, dmem_req_valid);
        end
        step;
        dmem_req_ready = 1'b0;
    endtask

    task automatic test_load(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] exp_out);
        drive(1'b1, ir, addr, 32'h0);
        dmem_req_ready = 1'b1;
        push(ir, exp_out, 1'b1);
        @(negedge clk);
        checks++;
        if ({dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wstrb, mem_stall} !==
            {1'b1, 1'b0, addr & 32'hFFFF_FFFC, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL load_req ir=%h got v=%b we=%b a=%h s=%b st=%b exp v=1 we=0 a=%h s=0000 st=1",
                     ir, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wstrb, mem_stall,
                     addr & 32'hFFFF_FFFC);
        end
        step;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = data;
        @(negedge clk);
        checks++;
        if ({dmem_req_valid, mem_stall} !== 2'b00) begin
            failures++;
            $display("FAIL load_rsp ir=%h got req=%b stall=%b exp 0 0", ir, dmem_req_valid, mem_stall);
        end
        step;
        dmem_rsp_valid = 1'b0;
        drive(1'b0, 32'h13, 32'h0, 32'h0);
    endtask

    task automatic test_store(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] rs2, input int waits,
                              input logic [31:0] exp_ir, input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        drive(1'b1, ir, addr, rs2);
        dmem_req_ready = 1'b0;
        push(exp_ir, 32'h0, 1'b0);
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) dmem_req_ready = 1'b1;
            @(negedge clk);
            checks++;
            if ({dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wstrb, dmem_req_wdata, mem_stall} !==
                {1'b1, 1'b1, addr & 32'hFFFF_FFFC, exp_strb, exp_wdata, i != waits}) begin
                failures++;
                $display("FAIL store_req ir=%h cyc=%0d got v=%b we=%b a=%h s=%b d=%h st=%b exp a=%h s=%b d=%h st=%b",
                         ir, i, dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wstrb, dmem_req_wdata,
                         mem_stall, addr & 32'hFFFF_FFFC, exp_strb, exp_wdata, i != waits);
            end
            step;
        end
        dmem_req_ready = 1'b0;
        drive(1'b0, 32'h13, 32'h0, 32'h0);
    endtask

    task automatic test_fault(input logic [31:0] ir, input logic [31:0] addr);
        drive(1'b1, ir, addr, 32'h1234_5678);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_req_valid, mem_stall} !== 2'b00) begin
            failures++;
            $display("FAIL fault_noreq ir=%h got req=%b stall=%b exp 0 0", ir, dmem_req_valid, mem_stall);
        end
        step;
        drive(1'b0, 32'h13, 32'h0, 32'h0);
        dmem_req_ready = 1'b0;
        checks++;
        if ({mem_fault, mem_wb_valid, mem_wb_ir} !== {1'b1, 1'b0, 32'h13}) begin
            failures++;
            $display("FAIL fault_pulse ir=%h got f=%b v=%b wbir=%h exp f=1 v=0 wbir=00000013",
                     ir, mem_fault, mem_wb_valid, mem_wb_ir);
        end
        step;
        checks++;
        if (mem_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear got f=%b exp 0", mem_fault);
        end
    endtask

    task automatic test_reset_in_rsp;
        drive(1'b1, 32'h0000A283, 32'h100, 32'h0);
        dmem_req_ready = 1'b1;
        step;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_stall, dmem_req_valid} !== 2'b10) begin
            failures++;
            $display("FAIL rsp_wait got stall=%b req=%b exp 1 0", mem_stall, dmem_req_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({dmem_req_valid, mem_wb_valid, mem_wb_ir, mem_wb_out, mem_fault} !== {1'b1, 1'b0, 32'h13, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got req=%b v=%b ir=%h out=%h f=%b exp req=1 v=0 ir=00000013 out=0 f=0",
                     dmem_req_valid, mem_wb_valid, mem_wb_ir, mem_wb_out, mem_fault);
        end
        drive(1'b0, 32'h13, 32'h0, 32'h0);
        step;
        rst = 1'b1;
        test_alu(32'h002081B3, 32'h77, 32'h002081B3);
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 32'h002081B3, 32'h11, 32'h0);
        push(32'h002081B3, 32'h11, 1'b1);
        step;
        drive(1'b1, 32'h40208233, 32'hFFFF_FFF0, 32'h0);
        push(32'h40208233, 32'hFFFF_FFF0, 1'b1);
        step;
        drive(1'b1, 32'h00A00293, 32'hA, 32'h0);
        push(32'h00A00293, 32'hA, 1'b1);
        step;
        test_load(32'h00009283, 32'h102, 32'h8123_4567, 32'hFFFF_8123);
        test_load(32'h0000D283, 32'h102, 32'h8123_4567, 32'h0000_8123);
        test_load(32'h0000A283, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    endtask

    initial begin
        test_reset;
        test_alu(32'h002081B3, 32'h55, 32'h002081B3);
        test_idle_noreq;
        test_load(32'h00008283, 32'h103, 32'h80FF_FF11, 32'hFFFF_FF80);
        test_load(32'h0000C283, 32'h103, 32'h80FF_FF11, 32'h0000_0080);
        test_store(32'h002092A3, 32'h202, 32'hABCD_1234, 3, 32'h00209023, 4'b1100, 32'h1234_1234);
        test_store(32'h0020A023, 32'h300, 32'hCAFE_F00D, 0, 32'h0020A023, 4'b1111, 32'hCAFE_F00D);
        test_store(32'h00208023, 32'h301, 32'h0000_00A5, 1, 32'h00208023, 4'b0010, 32'hA5A5_A5A5);
        test_fault(32'h0000A283, 32'h105);
        test_fault(32'h0020B023, 32'h100);
        test_fault(32'h00009283, 32'h101);
        test_reset_in_rsp;
        test_alu(32'h00208463, 32'h40, 32'h00208063);
        test_back_to_back;
        step;
        step;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got pending=%0d exp 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
